// File: rtl/demux_1to2.sv
// Registered 1-to-2 demultiplexer with valid/ready flow control.
// Each output channel owns a one-entry holding register, so a stall on one never blocks the other.
module demux_1to2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             sel,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data0,
    output logic             o_valid0,
    input  logic             i_ready0,
    output logic [WIDTH-1:0] o_data1,
    output logic             o_valid1,
    input  logic             i_ready1
);

    logic [WIDTH-1:0] data_reg0;
    logic [WIDTH-1:0] data_reg1;
    logic             valid_reg0;
    logic             valid_reg1;
    logic             xfer0;
    logic             xfer1;

    // A channel can take a new word when empty or when its current word drains this cycle.
    always_comb begin
        o_ready = sel ? (!valid_reg1 || i_ready1) : (!valid_reg0 || i_ready0);
        xfer0   = i_valid && o_ready && !sel;
        xfer1   = i_valid && o_ready && sel;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg0  <= '0;
            valid_reg0 <= 1'b0;
        end else if (xfer0) begin
            data_reg0  <= i_data;
            valid_reg0 <= 1'b1;
        end else if (i_ready0) begin
            valid_reg0 <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg1  <= '0;
            valid_reg1 <= 1'b0;
        end else if (xfer1) begin
            data_reg1  <= i_data;
            valid_reg1 <= 1'b1;
        end else if (i_ready1) begin
            valid_reg1 <= 1'b0;
        end
    end

    // Drained data stays in the register but is masked so idle channels read zero.
    always_comb begin
        o_valid0 = valid_reg0;
        o_valid1 = valid_reg1;
        o_data0  = valid_reg0 ? data_reg0 : '0;
        o_data1  = valid_reg1 ? data_reg1 : '0;
    end

endmodule

// File: tb/tb_demux_1to2.sv
// Self-checking bench for demux_1to2: directed vector table, reset corner case,
// and randomized traffic against a queue-based reference model.
module tb_demux_1to2;

    localparam int unsigned WIDTH = 32;

    logic             i_clk;
    logic             i_rst_n;
    logic [WIDTH-1:0] i_data;
    logic             sel;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_data0;
    logic             o_valid0;
    logic             i_ready0;
    logic [WIDTH-1:0] o_data1;
    logic             o_valid1;
    logic             i_ready1;

    demux_1to2 #(.WIDTH(WIDTH)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_data   (i_data),
        .sel      (sel),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_data0  (o_data0),
        .o_valid0 (o_valid0),
        .i_ready0 (i_ready0),
        .o_data1  (o_data1),
        .o_valid1 (o_valid1),
        .i_ready1 (i_ready1)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic             pre_ready;
    logic             pre_v0;
    logic             pre_v1;
    logic [WIDTH-1:0] pre_d0;
    logic [WIDTH-1:0] pre_d1;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             s;
        logic             v;
        logic             r0;
        logic             r1;
        logic             ready;
        logic             v0;
        logic [WIDTH-1:0] d0;
        logic             v1;
        logic [WIDTH-1:0] d1;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs (called just after a rising edge), sample pre-edge outputs
    // on the falling edge, and return 1 time unit after the next rising edge.
    task automatic cycle(input logic [WIDTH-1:0] d, input logic s, input logic v,
                         input logic r0, input logic r1);
        i_data   = d;
        sel      = s;
        i_valid  = v;
        i_ready0 = r0;
        i_ready1 = r1;
        @(negedge i_clk);
        pre_ready = o_ready;
        pre_v0    = o_valid0;
        pre_v1    = o_valid1;
        pre_d0    = o_data0;
        pre_d1    = o_data1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid0"}, {31'd0, o_valid0}, 32'd0);
        chk({tag, "_valid1"}, {31'd0, o_valid1}, 32'd0);
        chk({tag, "_data0"}, o_data0, 32'd0);
        chk({tag, "_data1"}, o_data1, 32'd0);
        chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    // Reference model: each channel is a FIFO of capacity one; accepted and delivered
    // words are logged separately to confirm order and no loss/duplication.
    logic [WIDTH-1:0] mq0[$];
    logic [WIDTH-1:0] mq1[$];
    logic [WIDTH-1:0] sent0[$];
    logic [WIDTH-1:0] sent1[$];
    logic [WIDTH-1:0] got0[$];
    logic [WIDTH-1:0] got1[$];

    task automatic model_cycle(input logic [WIDTH-1:0] d, input logic s, input logic v,
                               input logic r0, input logic r1);
        logic exp_ready;
        exp_ready = s ? (mq1.size() == 0 || r1) : (mq0.size() == 0 || r0);
        cycle(d, s, v, r0, r1);
        chk("rnd_ready", {31'd0, pre_ready}, {31'd0, exp_ready});
        if (pre_v0 && r0) got0.push_back(pre_d0);
        if (pre_v1 && r1) got1.push_back(pre_d1);
        if (r0 && mq0.size() != 0) void'(mq0.pop_front());
        if (r1 && mq1.size() != 0) void'(mq1.pop_front());
        if (v && exp_ready) begin
            if (s) begin mq1.push_back(d); sent1.push_back(d); end
            else   begin mq0.push_back(d); sent0.push_back(d); end
        end
        chk("rnd_valid0", {31'd0, o_valid0}, {31'd0, mq0.size() != 0});
        chk("rnd_valid1", {31'd0, o_valid1}, {31'd0, mq1.size() != 0});
        chk("rnd_data0", o_data0, (mq0.size() != 0) ? mq0[0] : 32'd0);
        chk("rnd_data1", o_data1, (mq1.size() != 0) ? mq1[0] : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n  = 1'b0;
        i_data   = '0;
        sel      = 1'b0;
        i_valid  = 1'b0;
        i_ready0 = 1'b0;
        i_ready1 = 1'b0;
        #2;
        chk_idle("rst_async");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk_idle("rst_release");

        //           d      s     v     r0    r1    ready v0    d0     v1    d1
        tbl[0]  = '{32'h1A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1A, 1'b0, 32'h00};
        tbl[1]  = '{32'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h07};
        tbl[2]  = '{32'h05, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h05, 1'b0, 32'h00};
        tbl[3]  = '{32'h09, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h05, 1'b0, 32'h00};
        tbl[4]  = '{32'h09, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h09, 1'b0, 32'h00};
        tbl[5]  = '{32'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h03, 1'b0, 32'h00};
        tbl[6]  = '{32'h1F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h03, 1'b1, 32'h1F};
        tbl[7]  = '{32'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h03, 1'b1, 32'h00};
        tbl[8]  = '{32'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h03, 1'b1, 32'h01};
        tbl[9]  = '{32'h02, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h03, 1'b1, 32'h02};
        tbl[10] = '{32'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h03, 1'b1, 32'h03};
        tbl[11] = '{32'h04, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h03, 1'b1, 32'h04};
        tbl[12] = '{32'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[13] = '{32'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].r0, tbl[i].r1);
            chk($sformatf("vec%0d_ready", i), {31'd0, pre_ready}, {31'd0, tbl[i].ready});
            chk($sformatf("vec%0d_valid0", i), {31'd0, o_valid0}, {31'd0, tbl[i].v0});
            chk($sformatf("vec%0d_data0", i), o_data0, tbl[i].d0);
            chk($sformatf("vec%0d_valid1", i), {31'd0, o_valid1}, {31'd0, tbl[i].v1});
            chk($sformatf("vec%0d_data1", i), o_data1, tbl[i].d1);
        end

        // Mid-cycle reset with channel 0 stalled on 0x11: must clear before any edge.
        cycle(32'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("hold_valid0", {31'd0, o_valid0}, 32'd1);
        chk("hold_data0", o_data0, 32'h11);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_idle("rst_mid");
        i_valid = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk_idle("rst_mid_release");

        for (int n = 0; n < 300; n++) begin
            model_cycle(WIDTH'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                        ($urandom_range(0, 2) != 0));
        end
        repeat (2) model_cycle('0, 1'b0, 1'b0, 1'b1, 1'b1);

        chk("sb0_count", got0.size(), sent0.size());
        chk("sb1_count", got1.size(), sent1.size());
        for (int k = 0; k < sent0.size() && k < got0.size(); k++)
            chk($sformatf("sb0_word%0d", k), got0[k], sent0[k]);
        for (int k = 0; k < sent1.size() && k < got1.size(); k++)
            chk($sformatf("sb1_word%0d", k), got1[k], sent1[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1to2.md
Name: demux_1to2

Overview:
Registered 1-to-2 demultiplexer with valid/ready flow control. Routes each input word to output channel 0 or 1 according to `sel`. Each output channel has its own one-entry holding register, so a stalled channel never blocks traffic to the other. Sits between a single producer and two independent consumers in the datapath.

Parameters:
- WIDTH, 32: data width in bits of `i_data`, `o_data0` and `o_data1`.

Ports:
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data  input  WIDTH  input word.
- sel  input  1  route select: 0 routes to channel 0, 1 routes to channel 1.
- i_valid  input  1  `i_data`/`sel` valid this cycle.
- o_ready  output  1  block can accept the input word this cycle.
- o_data0  output  WIDTH  channel 0 data.
- o_valid0  output  1  channel 0 holds a valid word.
- i_ready0  input  1  channel 0 consumer accepts this cycle.
- o_data1  output  WIDTH  channel 1 data.
- o_valid1  output  1  channel 1 holds a valid word.
- i_ready1  input  1  channel 1 consumer accepts this cycle.

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low on i_rst_n. While i_rst_n=0:
  - o_valid0=0, o_valid1=0.
  - Both internal data registers cleared to 0.
  - Hence o_data0=0, o_data1=0 and o_ready=1.
  - Deassertion takes effect on the next rising i_clk.
- Reset asserted mid-operation: held words are discarded immediately, not drained.
- Per-channel state N (N=0,1): data_regN and valid_regN. o_validN = valid_regN.
- o_dataN = data_regN when valid_regN=1, else 0. Idle channels always present zero.
- o_ready is combinational: sel=0 -> (!valid_reg0 | i_ready0); sel=1 -> (!valid_reg1 | i_ready1). Combinational path from i_readyN to o_ready is permitted.
- Input transfer: i_valid & o_ready on a rising edge. The word goes to channel `sel` only; the other channel is unaffected by that transfer.
- Channel N update each edge, in priority order:
  - Input transfer targeting N: data_regN<=i_data, valid_regN<=1. Load-and-drain in the same cycle is allowed, giving full throughput.
  - Else if i_readyN: valid_regN<=0; data_regN holds its value, but the output is masked to 0.
  - Else: hold.
- Latency: exactly 1 cycle from input transfer to o_validN=1.
- Throughput: 1 word/cycle when the target channel's consumer keeps i_readyN=1.
- Stall: while o_validN=1 and i_readyN=0, o_dataN is stable and o_validN stays high. o_ready=0 only if sel points at that stalled channel.
- i_valid=0: sel and i_data are ignored, no state change except drains. o_ready still reflects the channel selected by sel.
- i_validN is never dropped or altered by the block; no word is duplicated or lost.
- Both channels may present valid data simultaneously and drain independently in the same cycle.
- No X propagation: outputs are defined at all times after reset.

Test Plan:
- Reset check: assert i_rst_n=0 asynchronously mid-cycle with channel 0 holding 0x11 -> o_valid0/1=0, o_data0/1=0, o_ready=1 immediately, before any clock edge.
- Basic routing, WIDTH=32, both i_ready=1:
  - Send i_data=0x1A, sel=0 -> next cycle o_valid0=1, o_data0=0x1A, o_valid1=0, o_data1=0.
  - Then send 0x07, sel=1 -> o_data1=0x07, o_valid0=0, o_data0=0.
- Back-pressure: i_ready0=0, send 0x05 to ch0, then offer 0x09 sel=0 -> o_ready=0, o_data0 stays 0x05. Raise i_ready0 -> 0x09 accepted and appears next cycle.
- Independent channels: ch0 stalled holding 0x03, offer 0x1F with sel=1 and i_ready1=1 -> o_ready=1, o_data1=0x1F next cycle, ch0 unchanged.
- Full throughput: stream 0,1,2,3,4 to ch1 with i_ready1=1 on consecutive cycles -> o_data1 shows 0..4 on consecutive cycles, o_valid1 continuously high.
- Randomized: 5+ random words in 0..31 with random sel and readies -> a scoreboard per channel matches order and values exactly; an idle channel always reads 0.
